// File: rtl/read_src_fsm_pkg.sv
// Shared types and constants for the DMA source-side read engine.
package read_src_fsm_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int ST_IDLE_BIT       = 0;
   localparam int ST_ADDR_SETUP_BIT = 1;
   localparam int ST_RD_DATA_BIT    = 2;
   localparam int ST_ERROR_BIT      = 3;

   typedef enum logic [3:0] {
      IDLE       = 4'b0001,
      ADDR_SETUP = 4'b0010,
      RD_DATA    = 4'b0100,
      ERROR      = 4'b1000
   } t_rd_src_state;

   // SLVERR and DECERR both poison the beat; OKAY/EXOKAY are good data.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return !((resp == AXI_RESP_OKAY) || (resp == AXI_RESP_EXOKAY));
   endfunction

endpackage

// File: rtl/read_src_fsm_rd_burst_splitter.sv
// Splits the remaining transfer into AR bursts of at most MAX_BURST beats
// and precomputes the address/beat count after the current burst.
module rd_burst_splitter #(
   parameter int DATA_W    = 512,
   parameter int MAX_BURST = 64,
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 32,
   parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
   input  logic [ADDR_W-1:0] cur_addr,
   input  logic [LEN_W-1:0]  beats_left,
   output logic [BC_W-1:0]   burst_beats,
   output logic [ADDR_W-1:0] next_addr,
   output logic [LEN_W-1:0]  next_beats_left
);

   localparam int BEAT_SHIFT = $clog2(DATA_W / 8);

   // burst = min(beats_left, MAX_BURST); address wraps at the ADDR_W boundary
   always_comb begin
      burst_beats     = (beats_left >= LEN_W'(MAX_BURST)) ? BC_W'(MAX_BURST)
                                                          : beats_left[BC_W-1:0];
      next_addr       = cur_addr + (ADDR_W'(burst_beats) << BEAT_SHIFT);
      next_beats_left = beats_left - LEN_W'(burst_beats);
   end

endmodule

// File: rtl/read_src_fsm.sv
// Source-side read engine of the DMA dispatcher: issues AXI4 read bursts,
// pushes good R data into the shared data FIFO, reports busy/error/done.
module read_src_fsm
   import read_src_fsm_pkg::*;
#(
   parameter int DATA_W    = 512,
   parameter int MAX_BURST = 64,
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   // descriptor
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [LEN_W-1:0]      length,
   input  logic                  go,
   // CSR
   input  logic                  reset_dispatcher,
   output logic                  busy,
   output logic                  stopped_on_error,
   output logic                  rd_fsm_done,
   // AXI AR
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_W-1:0]     araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [3:0]            arid,
   // AXI R
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [DATA_W-1:0]     rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   // AXI write channels, unused by a read engine
   output logic                  awvalid,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [3:0]            awid,
   output logic                  wvalid,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  bready,
   // data FIFO
   output logic                  wr_en,
   output logic [DATA_W-1:0]     wr_data,
   input  logic                  almost_full
);

   localparam int BC_W = $clog2(MAX_BURST) + 1;

   t_rd_src_state     state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, next_addr;
   logic [LEN_W-1:0]  beats_left_q, next_beats_left;
   logic [BC_W-1:0]   beat_cnt_q, burst_beats;
   logic              err_seen_q, wr_en_q, done_q;
   logic [DATA_W-1:0] wr_data_q;

   logic r_hs, last_exp, beat_err;
   logic ld_desc, zero_done, adv_burst, push, fin, set_err, clr_err;

   rd_burst_splitter #(
      .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BC_W(BC_W)
   ) u_split (
      .cur_addr        (cur_addr_q),
      .beats_left      (beats_left_q),
      .burst_beats     (burst_beats),
      .next_addr       (next_addr),
      .next_beats_left (next_beats_left)
   );

   // Outputs decoded straight from state so async reset clears them at once
   assign busy             = state_q[ST_ADDR_SETUP_BIT] | state_q[ST_RD_DATA_BIT];
   assign stopped_on_error = state_q[ST_ERROR_BIT];
   assign arvalid          = state_q[ST_ADDR_SETUP_BIT];
   assign araddr           = cur_addr_q;
   assign arlen            = 8'(burst_beats) - 8'd1;
   assign arsize           = 3'($clog2(DATA_W / 8));
   assign arburst          = AXI_BURST_INCR;
   assign arid             = '0;
   assign rready           = state_q[ST_RD_DATA_BIT] & ~almost_full;

   assign awvalid = 1'b0;
   assign awaddr  = '0;
   assign awlen   = '0;
   assign awsize  = '0;
   assign awburst = '0;
   assign awid    = '0;
   assign wvalid  = 1'b0;
   assign wdata   = '0;
   assign wstrb   = '0;
   assign wlast   = 1'b0;
   assign bready  = 1'b1;

   assign wr_en       = wr_en_q;
   assign wr_data     = wr_data_q;
   assign rd_fsm_done = done_q;

   // A beat is bad if the burst is already poisoned, its resp is an error,
   // or rlast disagrees with the expected burst position.
   assign r_hs     = rvalid & rready;
   assign last_exp = (beat_cnt_q == burst_beats - BC_W'(1));
   assign beat_err = err_seen_q | resp_is_err(rresp) | (rlast != last_exp);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state and datapath control strobes
   always_comb begin
      state_d   = state_q;
      ld_desc   = 1'b0;
      zero_done = 1'b0;
      adv_burst = 1'b0;
      push      = 1'b0;
      fin       = 1'b0;
      set_err   = 1'b0;
      clr_err   = 1'b0;
      unique case (state_q)
         IDLE: if (go) begin
            ld_desc = 1'b1;
            if (length == '0) zero_done = 1'b1;
            else              state_d   = ADDR_SETUP;
         end
         ADDR_SETUP: if (arready) state_d = RD_DATA;
         RD_DATA: if (r_hs) begin
            push    = ~beat_err;
            set_err = beat_err;
            if (rlast && !last_exp) begin
               state_d = ERROR;           // early rlast: stop right away
            end else if (last_exp) begin
               if (beat_err) begin
                  state_d = ERROR;
               end else begin
                  adv_burst = 1'b1;
                  if (next_beats_left == '0) begin
                     state_d = IDLE;
                     fin     = 1'b1;
                  end else begin
                     state_d = ADDR_SETUP;
                  end
               end
            end
         end
         ERROR: if (reset_dispatcher) begin
            state_d = IDLE;
            clr_err = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address/length tracking, beat counter, error flag and registered FIFO push
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_addr_q   <= '0;
         beats_left_q <= '0;
         beat_cnt_q   <= '0;
         err_seen_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         done_q       <= 1'b0;
      end else begin
         wr_en_q <= push;
         done_q  <= fin | zero_done;
         if (push) wr_data_q <= rdata;
         if (ld_desc) begin
            cur_addr_q   <= src_addr;
            beats_left_q <= length;
         end else if (adv_burst) begin
            cur_addr_q   <= next_addr;
            beats_left_q <= next_beats_left;
         end
         if (state_q[ST_ADDR_SETUP_BIT] && arready) beat_cnt_q <= '0;
         else if (r_hs)                             beat_cnt_q <= beat_cnt_q + BC_W'(1);
         if (set_err)      err_seen_q <= 1'b1;
         else if (clr_err) err_seen_q <= 1'b0;
      end
   end

endmodule
